// File: rtl/fifo_pkg.sv
// Shared FIFO package: FIFO sizing reused by its write-side arbiter, the
// arbiter state type and an index-width helper.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Width needed to index n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side bundle of the FIFO write arbiter. The arbiter takes the
// slave view. The producers and the FIFO model take the master view.
interface fifo_wr_arbiter_if
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) ();

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_mask;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          busy;
    logic [IDX_W-1:0]              owner;

    modport slave (
        input  req, req_data, req_mask, fifo_full,
        output gnt, fifo_wr_en, fifo_wr_data, busy, owner
    );

    modport master (
        output req, req_data, req_mask, fifo_full,
        input  gnt, fifo_wr_en, fifo_wr_data, busy, owner
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority first-one finder. It scans ereq starting at index
// start and wraps modulo NUM_REQ. It returns the first set position.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] ereq,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] ereq_dbl;
    logic [2*NUM_REQ-1:0] ereq_shift;
    logic [NUM_REQ-1:0]   ereq_rot;
    logic [IDX_W-1:0]     offset;
    logic [IDX_W:0]       sum;

    // Rotate by doubling the vector. Bit k of ereq_rot is then ereq[(start+k) mod N].
    assign ereq_dbl   = {ereq, ereq};
    assign ereq_shift = ereq_dbl >> start;
    assign ereq_rot   = ereq_shift[NUM_REQ-1:0];
    assign found      = |ereq;

    // Lowest set bit of the rotated vector is the winner's distance from start.
    always_comb begin
        offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (ereq_rot[k]) begin
                offset = IDX_W'(k);
            end
        end
    end

    // Map the offset back to an absolute index, wrapping modulo NUM_REQ.
    always_comb begin
        sum = {1'b0, start} + {1'b0, offset};
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for the shared FIFO write port. The burst lock
// keeps one producer's words contiguous for up to MAX_BURST beats. After
// that, priority rotates. When the owner drops its request, the slot is
// handed to the next producer in the same cycle.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int MAX_BURST  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    fifo_wr_arbiter_if.slave    bus
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = idx_width(MAX_BURST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    // Successor index modulo NUM_REQ. This also works when NUM_REQ is not a power of two.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    arb_state_t         state_reg,  state_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]   owner_reg,  owner_next;
    logic [CNT_W-1:0]   burst_cnt_reg, burst_cnt_next;

    logic [NUM_REQ-1:0] ereq;
    logic [NUM_REQ-1:0] gnt_next;
    logic [NUM_REQ-1:0] gnt_out;
    logic [IDX_W-1:0]   owner_inc;
    logic [IDX_W-1:0]   pick_start;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [DATA_WIDTH-1:0] gated_data [NUM_REQ];

    assign ereq      = bus.req & bus.req_mask;
    assign owner_inc = wrap_inc(owner_reg);

    // In a burst, the finder is only consulted once the owner has let go.
    // Scanning then restarts just past the owner.
    assign pick_start = (state_reg == BURST) ? owner_inc : rr_ptr_reg;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .ereq  (ereq),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Arbiter state register; reset abandons any burst in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            burst_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            owner_reg     <= owner_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

    // Next state and grant. A full FIFO freezes everything and grants nothing.
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        owner_next     = owner_reg;
        burst_cnt_next = burst_cnt_reg;
        gnt_next       = '0;
        if (!bus.fifo_full) begin
            if (state_reg == BURST && ereq[owner_reg]) begin
                gnt_next[owner_reg] = 1'b1;
                burst_cnt_next      = burst_cnt_reg + 1'b1;
                if (burst_cnt_reg == CNT_LAST) begin
                    state_next  = IDLE;
                    rr_ptr_next = owner_inc;
                end
            end else if (pick_found) begin
                gnt_next[pick_idx] = 1'b1;
                owner_next         = pick_idx;
                if (MAX_BURST == 1) begin
                    state_next  = IDLE;
                    rr_ptr_next = wrap_inc(pick_idx);
                end else begin
                    state_next     = BURST;
                    burst_cnt_next = CNT_W'(1);
                end
            end else if (state_reg == BURST) begin
                state_next  = IDLE;
                rr_ptr_next = owner_inc;
            end
        end
    end

    // Grants are combinational. They are held off while reset is asserted.
    assign gnt_out        = reset_n ? gnt_next : '0;
    assign bus.gnt        = gnt_out;
    assign bus.fifo_wr_en = |gnt_out;
    assign bus.busy       = (state_reg == BURST);
    assign bus.owner      = owner_reg;

    // AND-OR data mux. The grant is one-hot or zero, so no grant yields zero.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data_gate
        assign gated_data[gi] = gnt_out[gi]
                              ? bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH]
                              : '0;
    end

    // OR-reduce the gated words onto the FIFO write data.
    always_comb begin
        bus.fifo_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.fifo_wr_data = bus.fifo_wr_data | gated_data[i];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter. One instance runs with MAX_BURST=4
// and one with MAX_BURST=2. Each beat drives inputs just after a rising
// edge and checks the combinational outputs mid-cycle. Each beat prints
// one line.
module tb_fifo_wr_arbiter;
    import fifo_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus4 ();
    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus2 ();

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) u_arb4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4.slave)
    );

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(2)) u_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check one cycle's outputs on the selected instance (0: MAX_BURST=4, 1: MAX_BURST=2), then advance.
    task automatic beat(input string tag, input int sel, input logic [3:0] exp_gnt,
                        input logic [7:0] exp_data, input logic exp_busy);
        logic [3:0] g;
        logic       we;
        logic [7:0] d;
        logic       b;
        #1;
        if (sel == 0) begin
            g = bus4.gnt; we = bus4.fifo_wr_en; d = bus4.fifo_wr_data; b = bus4.busy;
        end else begin
            g = bus2.gnt; we = bus2.fifo_wr_en; d = bus2.fifo_wr_data; b = bus2.busy;
        end
        check({tag, "_gnt"},   32'(g),  32'(exp_gnt));
        check({tag, "_wr_en"}, 32'(we), 32'(|exp_gnt));
        check({tag, "_data"},  32'(d),  32'(exp_data));
        check({tag, "_busy"},  32'(b),  32'(exp_busy));
        $display("[%0t] %s gnt=%b wr_en=%b data=0x%02h busy=%b", $time, tag, g, we, d, b);
        tick();
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        bus4.req       = '0;
        bus4.req_mask  = '1;
        bus4.fifo_full = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic set_data4(input logic [7:0] base);
        for (int i = 0; i < N; i++) begin
            bus4.req_data[i*DW +: DW] = base + 8'(i);
        end
    endtask

    initial begin
        // Requests are active during reset. The outputs must still be forced to zero.
        bus4.req = '1; bus4.req_mask = '1; bus4.fifo_full = 1'b0;
        bus2.req = '1; bus2.req_mask = '1; bus2.fifo_full = 1'b0;
        set_data4(8'h70);
        for (int i = 0; i < N; i++) bus2.req_data[i*DW +: DW] = 8'hA0 + 8'(i);
        #2;
        check("rst_gnt4",   32'(bus4.gnt),          32'h0);
        check("rst_wren4",  32'(bus4.fifo_wr_en),   32'h0);
        check("rst_data4",  32'(bus4.fifo_wr_data), 32'h0);
        check("rst_busy4",  32'(bus4.busy),         32'h0);
        check("rst_owner4", 32'(bus4.owner),        32'h0);
        check("rst_gnt2",   32'(bus2.gnt),          32'h0);
        tick();
        tick();
        reset_n  = 1'b1;
        bus4.req = '0;
        bus2.req = '0;

        // MAX_BURST=2, all four requesting: pairs rotate with no idle cycle.
        bus2.req = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            int e;
            e = (k / 2) % 4;
            beat($sformatf("rr2_b%0d", k), 1, 4'(1 << e), 8'hA0 + 8'(e), logic'(k % 2));
        end
        bus2.req = '0;

        // Single requester: 10 back-to-back words. The burst ends after every 4th beat.
        do_reset();
        bus4.req = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            bus4.req_data[2*DW +: DW] = 8'h10 + 8'(k);
            beat($sformatf("single_b%0d", k), 0, 4'b0100, 8'h10 + 8'(k), logic'((k % 4) != 0));
        end
        bus4.req = '0;
        beat("single_drop", 0, 4'b0000, 8'h00, 1'b1);
        beat("single_idle", 0, 4'b0000, 8'h00, 1'b0);
        check("single_owner", 32'(bus4.owner), 32'd2);

        // Owner 1 drops after 2 beats. Producer 3 is granted in the same cycle.
        do_reset();
        set_data4(8'h30);
        bus4.req = 4'b1010;
        beat("drop_b0", 0, 4'b0010, 8'h31, 1'b0);
        beat("drop_b1", 0, 4'b0010, 8'h31, 1'b1);
        bus4.req = 4'b1000;
        beat("drop_hand", 0, 4'b1000, 8'h33, 1'b1);
        beat("drop_3b2", 0, 4'b1000, 8'h33, 1'b1);
        beat("drop_3b3", 0, 4'b1000, 8'h33, 1'b1);
        beat("drop_3b4", 0, 4'b1000, 8'h33, 1'b1);
        // The pointer has wrapped to 0, so producer 0 beats producer 3.
        bus4.req = 4'b1001;
        beat("drop_ptr0", 0, 4'b0001, 8'h30, 1'b0);
        bus4.req = '0;

        // FIFO full mid-burst at burst_cnt=2 freezes the burst. Then 2 more beats, then rotate.
        do_reset();
        set_data4(8'h40);
        bus4.req = 4'b0101;
        beat("full_b0", 0, 4'b0001, 8'h40, 1'b0);
        beat("full_b1", 0, 4'b0001, 8'h40, 1'b1);
        bus4.fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            beat($sformatf("full_hold%0d", k), 0, 4'b0000, 8'h00, 1'b1);
        end
        bus4.fifo_full = 1'b0;
        beat("full_b2", 0, 4'b0001, 8'h40, 1'b1);
        beat("full_b3", 0, 4'b0001, 8'h40, 1'b1);
        beat("full_rot", 0, 4'b0100, 8'h42, 1'b0);
        check("full_owner", 32'(bus4.owner), 32'd2);
        bus4.req = '0;

        // Mask 1010 admits only producers 1 and 3. Unmasking 0 mid-burst waits for the next arbitration.
        do_reset();
        set_data4(8'h50);
        bus4.req      = 4'b1111;
        bus4.req_mask = 4'b1010;
        beat("mask_b0", 0, 4'b0010, 8'h51, 1'b0);
        beat("mask_b1", 0, 4'b0010, 8'h51, 1'b1);
        beat("mask_b2", 0, 4'b0010, 8'h51, 1'b1);
        beat("mask_b3", 0, 4'b0010, 8'h51, 1'b1);
        beat("mask_b4", 0, 4'b1000, 8'h53, 1'b0);
        beat("mask_b5", 0, 4'b1000, 8'h53, 1'b1);
        bus4.req_mask = 4'b1011;
        beat("mask_b6", 0, 4'b1000, 8'h53, 1'b1);
        beat("mask_b7", 0, 4'b1000, 8'h53, 1'b1);
        beat("mask_b8", 0, 4'b0001, 8'h50, 1'b0);
        bus4.req      = '0;
        bus4.req_mask = '1;

        // Reset pulse during owner 3's burst forces the outputs to zero at once. Producer 0 wins afterwards.
        do_reset();
        set_data4(8'h60);
        bus4.req = 4'b1000;
        beat("rstp_b0", 0, 4'b1000, 8'h63, 1'b0);
        beat("rstp_b1", 0, 4'b1000, 8'h63, 1'b1);
        bus4.req = 4'b1111;
        reset_n  = 1'b0;
        #1;
        check("rstp_gnt",   32'(bus4.gnt),          32'h0);
        check("rstp_wren",  32'(bus4.fifo_wr_en),   32'h0);
        check("rstp_data",  32'(bus4.fifo_wr_data), 32'h0);
        check("rstp_busy",  32'(bus4.busy),         32'h0);
        check("rstp_owner", 32'(bus4.owner),        32'h0);
        tick();
        reset_n = 1'b1;
        beat("rstp_first", 0, 4'b0001, 8'h60, 1'b0);
        bus4.req = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
